// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the program/data RAM access controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } ram_ctrl_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } ram_owner_t;

    localparam logic SEL_PROGRAM = 1'b0;
    localparam logic SEL_DATA    = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way tie-breaker between fetch and load/store, with fixed data priority option.
// Latency: combinational grant; last-grant register updates on the accepting edge.
// Backpressure: grant is only consumed when update_i is high (controller in IDLE).
module ram_arbiter_rr
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned PRIO_DATA = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fetch_req_i,
    input  logic       data_req_i,
    input  logic       update_i,
    output logic       grant_vld_o,
    output ram_owner_t grant_owner_o
);

    // Owner of the most recent accepted grant; reset to DATA so the first tie goes to fetch.
    ram_owner_t r_lastGrant;

    // Pick a winner: single requester wins outright; a tie uses priority or alternation.
    always_comb begin
        grant_vld_o   = fetch_req_i | data_req_i;
        grant_owner_o = FETCH;
        if (fetch_req_i && data_req_i) begin
            if (PRIO_DATA != 0) begin
                grant_owner_o = DATA;
            end else begin
                grant_owner_o = (r_lastGrant == DATA) ? FETCH : DATA;
            end
        end else if (data_req_i) begin
            grant_owner_o = DATA;
        end
    end

    // Remember who was served last, only when the controller actually takes the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lastGrant <= DATA;
        end else if (update_i && grant_vld_o) begin
            r_lastGrant <= grant_owner_o;
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences fetch and load/store accesses onto the shared program/data RAM.
// Latency: request seen in IDLE at cycle N -> address N+1, access N+2, done N+3.
// Backpressure: requests are levels held until done; one access in flight at a time.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PRIO_DATA = 0
) (
    input  logic              i_clk,
    input  logic              i_nReset,
    input  logic              i_fetchReq,
    input  logic [ADDR_W-1:0] i_fetchAddr,
    output logic              o_fetchDone,
    output logic [DATA_W-1:0] o_fetchData,
    input  logic              i_dataReq,
    input  logic              i_dataWe,
    input  logic [ADDR_W-1:0] i_dataAddr,
    input  logic [DATA_W-1:0] i_dataWData,
    output logic              o_dataDone,
    output logic [DATA_W-1:0] o_dataRData,
    output logic [ADDR_W-1:0] o_ramAddress,
    output logic              o_ramAddressEn,
    output logic [DATA_W-1:0] o_ramWriteData,
    output logic              o_ramWriteEn,
    output logic              o_ramReadDataSelect,
    output logic              o_ramOutEnable,
    input  logic [DATA_W-1:0] i_ramReadData,
    output logic              o_busy
);

    ram_ctrl_state_t   state_q, state_d;
    ram_owner_t        owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic [DATA_W-1:0] data_rdata_q;

    logic              grant_vld;
    ram_owner_t        grant_owner;
    logic              grant_take;
    logic              addr_en;
    logic              write_en;
    logic              out_en;
    logic              fetch_done;
    logic              data_done;

    ram_arbiter_rr #(
        .PRIO_DATA (PRIO_DATA)
    ) u_arb (
        .clk_i         (i_clk),
        .rst_ni        (i_nReset),
        .fetch_req_i   (i_fetchReq),
        .data_req_i    (i_dataReq),
        .update_i      (grant_take),
        .grant_vld_o   (grant_vld),
        .grant_owner_o (grant_owner)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and RAM strobes; the address strobe always precedes the write strobe by one cycle.
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        addr_en    = 1'b0;
        write_en   = 1'b0;
        out_en     = 1'b0;
        fetch_done = 1'b0;
        data_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    grant_take = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                addr_en = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    write_en = 1'b1;
                end else begin
                    out_en = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q == DATA) begin
                    data_done = 1'b1;
                end else begin
                    fetch_done = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Freeze the winning request at grant so later input changes cannot disturb the access.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            owner_q <= FETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant_take) begin
            owner_q <= grant_owner;
            if (grant_owner == DATA) begin
                addr_q  <= i_dataAddr;
                we_q    <= i_dataWe;
                wdata_q <= i_dataWData;
            end else begin
                // A fetch is always a read, whatever the store port is showing.
                addr_q  <= i_fetchAddr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
        end
    end

    // Capture the RAM bus only while it is driven, into the owning port's result register.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else if (out_en) begin
            if (owner_q == DATA) begin
                data_rdata_q <= i_ramReadData;
            end else begin
                fetch_data_q <= i_ramReadData;
            end
        end
    end

    assign o_ramAddress        = addr_q;
    assign o_ramAddressEn      = addr_en;
    assign o_ramWriteData      = wdata_q;
    assign o_ramWriteEn        = write_en;
    assign o_ramOutEnable      = out_en;
    assign o_ramReadDataSelect = (owner_q == DATA) ? SEL_DATA : SEL_PROGRAM;
    assign o_fetchDone         = fetch_done;
    assign o_dataDone          = data_done;
    assign o_fetchData         = fetch_data_q;
    assign o_dataRData         = data_rdata_q;
    assign o_busy              = (state_q != IDLE);

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: a behavioural RAM, a transaction-level reference model and checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic       fetch_req1 = 1'b0, data_req1 = 1'b0;
    logic [7:0] fetch_addr = '0, data_addr = '0, data_wdata = '0;

    // instance 0 (round-robin) outputs
    logic       fdone0, ddone0, aen0, wen0, sel0, oe0, busy0;
    logic [7:0] fdata0, ddata0, addr0, wdat0, rbus0;
    // instance 1 (data priority) outputs
    logic       fdone1, ddone1, aen1, wen1, sel1, oe1, busy1;
    logic [7:0] fdata1, ddata1, addr1, wdat1, rbus1;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .PRIO_DATA(0)) u_dut (
        .i_clk(clk), .i_nReset(nreset),
        .i_fetchReq(fetch_req), .i_fetchAddr(fetch_addr), .o_fetchDone(fdone0), .o_fetchData(fdata0),
        .i_dataReq(data_req), .i_dataWe(data_we), .i_dataAddr(data_addr), .i_dataWData(data_wdata),
        .o_dataDone(ddone0), .o_dataRData(ddata0),
        .o_ramAddress(addr0), .o_ramAddressEn(aen0), .o_ramWriteData(wdat0), .o_ramWriteEn(wen0),
        .o_ramReadDataSelect(sel0), .o_ramOutEnable(oe0), .i_ramReadData(rbus0), .o_busy(busy0)
    );

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .PRIO_DATA(1)) u_dut_prio (
        .i_clk(clk), .i_nReset(nreset),
        .i_fetchReq(fetch_req1), .i_fetchAddr(fetch_addr), .o_fetchDone(fdone1), .o_fetchData(fdata1),
        .i_dataReq(data_req1), .i_dataWe(data_we), .i_dataAddr(data_addr), .i_dataWData(data_wdata),
        .o_dataDone(ddone1), .o_dataRData(ddata1),
        .o_ramAddress(addr1), .o_ramAddressEn(aen1), .o_ramWriteData(wdat1), .o_ramWriteEn(wen1),
        .o_ramReadDataSelect(sel1), .o_ramOutEnable(oe1), .i_ramReadData(rbus1), .o_busy(busy1)
    );

    // Behavioural RAM: registered address, write into data section, bus floats (0xEE) unless enabled.
    logic [7:0] ram_p [256];
    logic [7:0] ram_d [256];
    logic [7:0] areg0 = '0, areg1 = '0;
    always @(posedge clk) begin
        if (aen0) areg0 <= addr0;
        if (wen0) ram_d[areg0] <= wdat0;
        if (aen1) areg1 <= addr1;
    end
    assign rbus0 = oe0 ? (sel0 ? ram_d[areg0] : ram_p[areg0]) : 8'hEE;
    assign rbus1 = oe1 ? (sel1 ? ram_d[areg1] : ram_p[areg1]) : 8'hEE;

    // Reference model state
    logic [7:0] ref_p [256];
    logic [7:0] ref_d [256];
    logic [7:0] last_fd = '0, last_dd = '0;
    bit         ref_last = 1'b1;   // 1 = data served last

    int n_vec = 0, n_err = 0;
    int cyc = 0, wen_cnt = 0, ovl_cnt = 0, done_cnt = 0;
    int acc_cyc0[$], acc_cyc1[$];
    bit acc_own0[$], acc_own1[$];

    always @(posedge clk) cyc++;

    // Observe RAM cycles: who accessed when, write strobes, illegal strobe overlaps.
    always @(negedge clk) begin
        if (wen0) wen_cnt++;
        if (wen0 && (aen0 || oe0)) ovl_cnt++;
        if (wen1) ovl_cnt++;
        if (oe0 || wen0) begin
            acc_cyc0.push_back(cyc);
            acc_own0.push_back(wen0 ? 1'b1 : sel0);
        end
        if (oe1) begin
            acc_cyc1.push_back(cyc);
            acc_own1.push_back(sel1);
        end
        if (fdone0 || ddone0) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One isolated access on instance 0; caller is just after a posedge with the DUT idle.
    task automatic run_txn(input bit is_data, input bit we, input logic [7:0] addr,
                           input logic [7:0] wd, input bit mid_chg);
        int w0;
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr; data_we = 1'($urandom); data_wdata = 8'($urandom);
        end
        w0 = wen_cnt;
        @(negedge clk);
        check_val("idle_busy", busy0, 0);
        check_val("idle_aen", aen0, 0);
        check_val("idle_done", fdone0 | ddone0, 0);
        @(negedge clk);
        check_val("addr_en", aen0, 1);
        check_val("addr_val", addr0, addr);
        check_val("addr_wen", wen0, 0);
        check_val("addr_oe", oe0, 0);
        @(posedge clk); #1;
        if (mid_chg) begin
            data_addr = addr ^ 8'h10; fetch_addr = addr ^ 8'h10; data_wdata = ~wd;
        end
        @(negedge clk);
        check_val("acc_aen", aen0, 0);
        check_val("acc_addr", addr0, addr);
        if (is_data && we) begin
            check_val("st_wen", wen0, 1);
            check_val("st_wdata", wdat0, wd);
            check_val("st_oe", oe0, 0);
        end else begin
            check_val("rd_oe", oe0, 1);
            check_val("rd_sel", sel0, is_data);
            check_val("rd_wen", wen0, 0);
        end
        @(negedge clk);
        check_val("resp_fdone", fdone0, !is_data);
        check_val("resp_ddone", ddone0, is_data);
        if (!is_data) last_fd = ref_p[addr];
        else if (!we) last_dd = ref_d[addr];
        else ref_d[addr] = wd;
        check_val("resp_fdata", fdata0, last_fd);
        check_val("resp_ddata", ddata0, last_dd);
        check_val("wen_count", wen_cnt - w0, (is_data && we) ? 1 : 0);
        ref_last = is_data;
        @(posedge clk); #1;
        fetch_req = 1'b0; data_req = 1'b0;
    endtask

    // Fetch and load held together for four accesses on the chosen instance.
    task automatic tie_test(input bit inst);
        int nd;
        bit e;
        logic [7:0] fa, da;
        fa = 8'($urandom); da = 8'($urandom);
        fetch_addr = fa; data_addr = da; data_we = 1'b0;
        acc_cyc0.delete(); acc_own0.delete(); acc_cyc1.delete(); acc_own1.delete();
        if (inst) begin fetch_req1 = 1'b1; data_req1 = 1'b1; end
        else begin fetch_req = 1'b1; data_req = 1'b1; end
        nd = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            @(negedge clk);
            if (!inst) begin
                if (fdone0) check_val("tie_fdata", fdata0, ref_p[fa]);
                if (ddone0) check_val("tie_ddata", ddata0, ref_d[da]);
                nd += int'(fdone0) + int'(ddone0);
            end else begin
                if (ddone1) check_val("prio_ddata", ddata1, ref_d[da]);
                nd += int'(fdone1) + int'(ddone1);
            end
        end
        check_val("tie_dones", nd, 4);
        @(posedge clk); #1;
        fetch_req = 1'b0; data_req = 1'b0; fetch_req1 = 1'b0; data_req1 = 1'b0;
        if (!inst) begin
            check_val("tie_count", acc_own0.size(), 4);
            for (int i = 0; i < acc_own0.size(); i++) begin
                e = ~ref_last;
                ref_last = e;
                check_val("tie_owner", acc_own0[i], e);
                if (i > 0) check_val("tie_spacing", acc_cyc0[i] - acc_cyc0[i-1], 4);
            end
            last_fd = ref_p[fa]; last_dd = ref_d[da];
        end else begin
            check_val("prio_count", acc_own1.size(), 4);
            for (int i = 0; i < acc_own1.size(); i++) begin
                check_val("prio_owner", acc_own1[i], 1);
                if (i > 0) check_val("prio_spacing", acc_cyc1[i] - acc_cyc1[i-1], 4);
            end
        end
    endtask

    // Fetch held continuously: done every 4 cycles, one idle cycle between accesses.
    task automatic b2b_test();
        int nd, nlow, c0;
        int dc[3];
        logic [7:0] a;
        a = 8'($urandom);
        fetch_addr = a; fetch_req = 1'b1;
        nd = 0; nlow = 0;
        dc[0] = 0; dc[1] = 0; dc[2] = 0;
        @(negedge clk);
        c0 = cyc;
        for (int c = 0; c < 30 && nd < 3; c++) begin
            if (fdone0) begin
                dc[nd] = cyc;
                nd++;
                check_val("b2b_fdata", fdata0, ref_p[a]);
            end else if (nd >= 1 && !busy0) begin
                nlow++;
            end
            if (nd < 3) @(negedge clk);
        end
        check_val("b2b_dones", nd, 3);
        check_val("b2b_first", dc[0] - c0, 3);
        check_val("b2b_gap1", dc[1] - dc[0], 4);
        check_val("b2b_gap2", dc[2] - dc[1], 4);
        check_val("b2b_idle", nlow, 2);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        ref_last = 1'b0;
        last_fd = ref_p[a];
    endtask

    // Reset pulled in the ADDR cycle of a store; the held store must restart cleanly.
    task automatic reset_store_test();
        int w0, d0;
        logic [7:0] a, wd;
        a = 8'($urandom);
        wd = ref_d[a] ^ 8'h5A;
        data_req = 1'b1; data_we = 1'b1; data_addr = a; data_wdata = wd;
        w0 = wen_cnt; d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_pre_aen", aen0, 1);
        #2 nreset = 1'b0;
        #1;
        check_val("rst_aen", aen0, 0);
        check_val("rst_wen", wen0, 0);
        check_val("rst_oe", oe0, 0);
        check_val("rst_busy", busy0, 0);
        check_val("rst_done", fdone0 | ddone0, 0);
        check_val("rst_addr", addr0, 0);
        check_val("rst_wdat", wdat0, 0);
        check_val("rst_fdata", fdata0, 0);
        check_val("rst_ddata", ddata0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        nreset = 1'b1;
        check_val("rst_no_write", wen_cnt - w0, 0);
        check_val("rst_no_done", done_cnt - d0, 0);
        check_val("rst_mem_kept", ram_d[a], ref_d[a]);
        last_fd = '0; last_dd = '0; ref_last = 1'b1;
        run_txn(1'b1, 1'b1, a, wd, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_p[i] = 8'($urandom);
            ref_d[i] = 8'($urandom);
        end
        ref_p[8'h10] = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            ram_p[i] <= ref_p[i];
            ram_d[i] <= ref_d[i];
        end
        #1;
        check_val("reset_busy", busy0, 0);
        check_val("reset_strobes", {aen0, wen0, oe0, fdone0, ddone0}, 0);
        check_val("reset_addr", addr0, 0);
        check_val("reset_fdata", fdata0, 0);
        check_val("reset_ddata", ddata0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);          // single fetch of 0xA5
        run_txn(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);          // store 0x3C
        run_txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);          // load it back
        tie_test(1'b0);
        tie_test(1'b1);
        b2b_test();
        reset_store_test();
        run_txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b1);          // address changes mid-access
        run_txn(1'b1, 1'b1, 8'h20, 8'h96, 1'b1);
        run_txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_txn(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        tie_test(1'b0);

        check_val("strobe_overlap", ovl_cnt, 0);
        check_val("prio_idle", busy1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Sequencer and arbiter in front of the shared program/data RAM (registered address, distributed memory, tri-stated read port). It shares the RAM between two requesters: the instruction-fetch unit, which reads the program section only, and the load/store unit, which reads and writes the data section. It generates the address-load, write and output-enable strobes in the order the RAM requires, and returns read data to the requester that owns the access.

## Interface
- `ADDR_W`, default 8: RAM address width.
- `DATA_W`, default 8: RAM data width.
- `PRIO_DATA`, default 0: 1 = load/store always wins a tie; 0 = round-robin on a tie.

Ports (name, direction, width, meaning):
- `i_clk` in 1: the single clock.
- `i_nReset` in 1: reset, asynchronous, active-low.
- `i_fetchReq` in 1: fetch read request; level signal, held until `o_fetchDone`.
- `i_fetchAddr` in ADDR_W: fetch address.
- `o_fetchDone` out 1: one-cycle completion pulse.
- `o_fetchData` out DATA_W: fetched byte; valid with `o_fetchDone`, then held.
- `i_dataReq` in 1: load/store request; level signal, held until `o_dataDone`.
- `i_dataWe` in 1: 1 = store, 0 = load.
- `i_dataAddr` in ADDR_W: data address.
- `i_dataWData` in DATA_W: store data.
- `o_dataDone` out 1: one-cycle completion pulse.
- `o_dataRData` out DATA_W: load result; valid with `o_dataDone`, then held.
- `o_ramAddress` out ADDR_W: goes to the RAM address input.
- `o_ramAddressEn` out 1: RAM address-register load strobe.
- `o_ramWriteData` out DATA_W: RAM write data.
- `o_ramWriteEn` out 1: RAM write strobe.
- `o_ramReadDataSelect` out 1: 1 = data section, 0 = program section.
- `o_ramOutEnable` out 1: RAM bus driver enable.
- `i_ramReadData` in DATA_W: RAM read bus.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
State machine: IDLE -> ADDR -> ACCESS -> RESP -> IDLE.

- **IDLE**
  - Samples both requests.
  - If neither is pending, stays in IDLE.
  - If exactly one is pending, grants it.
  - If both are pending:
    - `PRIO_DATA`=1: grants load/store.
    - `PRIO_DATA`=0: grants the requester not granted last time, using register `r_lastGrant`.
  - On a grant, latches owner, address, `we` and `wdata` into internal registers, updates `r_lastGrant`, and goes to ADDR.
- **ADDR**
  - `o_ramAddressEn`=1, `o_ramAddress`=latched address.
  - The RAM loads its address register at the end of this cycle.
- **ACCESS, read (fetch or load)**
  - `o_ramOutEnable`=1.
  - `o_ramReadDataSelect`=0 for fetch, 1 for load.
  - `i_ramReadData` is captured into the owner's read-data register at the end of the cycle.
- **ACCESS, store**
  - `o_ramWriteEn`=1, `o_ramWriteData`=latched data, `o_ramOutEnable`=0.
  - The RAM always writes to the data section.
- **RESP**
  - Pulses the owner's done signal for one cycle, then goes to IDLE.
  - The requester must drop, or re-present, its request at the edge that ends RESP.
  - A request still high in IDLE is treated as a new access.
- **Strobe defaults:** `o_ramAddressEn`, `o_ramWriteEn` and `o_ramOutEnable` are 0 in every state not listed above. The RAM therefore never drives the bus outside a read ACCESS cycle.
- **Stores:** the store read-data register is not updated. `o_dataRData` keeps its previous value.
- **Input changes during an access:** changes to request inputs after the grant have no effect on the access in flight.
- **Fetch and writes:** a fetch never writes.

## Timing
- **Latency:**
  - Request first sampled high in IDLE in cycle N: ADDR is N+1, ACCESS is N+2, done is high in N+3.
  - Sustained throughput: one access per 4 cycles.
- **Reset (`i_nReset` low, asynchronous):**
  - State goes to IDLE.
  - All strobes, done signals and `o_busy` go to 0.
  - `o_ramAddress`, `o_fetchData`, `o_dataRData` and latched data go to 0.
  - `r_lastGrant` goes to data, so the first tie goes to fetch.
- **Reset mid-operation:**
  - The access is aborted with no done pulse.
  - An aborted store is not written if reset lands before the ACCESS edge.
  - After reset release, the requester's still-held request is re-arbitrated from IDLE.
- **Release:** reset is released synchronously to `i_clk` by the system reset synchroniser. The first active edge sees IDLE.
- **Write ordering:** the address is always loaded one cycle before the write strobe. The write strobe never coincides with `o_ramAddressEn`.

## Structure
- Package `ram_ctrl_pkg`:
  - `ram_ctrl_state_t` enum: IDLE, ADDR, ACCESS, RESP.
  - `ram_owner_t` enum: FETCH, DATA.
  - Constants `SEL_PROGRAM`=0 and `SEL_DATA`=1 for `o_ramReadDataSelect`.
- Sub-module `ram_arbiter_rr`: a two-way tie-breaker with a `PRIO_DATA` override and the `r_lastGrant` register. Its grant is used only in IDLE.
- The top level holds the FSM, the latch registers and the per-port read-data registers. Total RTL is about 150-200 lines.

## Test plan
- **Single fetch:**
  - Stimulus: fetch only, `i_fetchAddr`=0x10, RAM program[0x10]=0xA5.
  - Response: AddressEn in cycle N+1 with address 0x10; OutEnable with Select=0 in N+2; `o_fetchDone` in N+3 with `o_fetchData`=0xA5.
- **Store then load:**
  - Stimulus: store 0x3C to data address 0x20, then load 0x20.
  - Response: WriteEn in exactly one cycle with WriteData 0x3C; no OutEnable during the store; the load returns 0x3C with Select=1.
- **Ties:**
  - Stimulus: fetch and load held high together for 4 accesses, `PRIO_DATA`=0.
  - Response: grants alternate fetch, data, fetch, data, each 4 cycles apart.
  - Stimulus: the same with `PRIO_DATA`=1.
  - Response: data is granted on every tie.
- **Back-to-back fetch:**
  - Stimulus: fetch request held high continuously.
  - Response: done every 4 cycles; `o_busy` low exactly one cycle between accesses.
- **Reset during a store:**
  - Stimulus: `i_nReset` pulled low in the ADDR cycle of a store.
  - Response: no WriteEn, no done; all outputs 0 immediately; the held store completes after release with a fresh 4-cycle sequence.
- **Input change mid-access:**
  - Stimulus: change `i_dataAddr` from 0x20 to 0x30 during ACCESS.
  - Response: the in-flight access still uses 0x20.
